// File: rtl/rmw_mem_pkg.sv
// Shared encodings and helpers for the read-modify-write register memory.
package rmw_mem_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_INC   = 2'd1,
        OP_COPY  = 2'd2,
        OP_WRITE = 2'd3
    } op_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/rmw_mem_alu.sv
// Combinational op decode: computes the value an op leaves in its target entry.
module rmw_mem_alu
    import rmw_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] src_val,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] new_val,
    output logic              we
);

    always_comb begin
        new_val = old_val;
        we      = 1'b0;
        unique case (op)
            OP_READ:  we = 1'b0;
            OP_INC: begin
                new_val = old_val + DATA_W'(1);
                we      = 1'b1;
            end
            OP_COPY: begin
                new_val = src_val;
                we      = 1'b1;
            end
            OP_WRITE: begin
                new_val = wr_data;
                we      = 1'b1;
            end
            default: we = 1'b0;
        endcase
    end

endmodule

// File: rtl/rmw_mem.sv
// Read-modify-write register memory: two-stage pipeline with stage-2 -> stage-1
// forwarding, preceded by a clear walk that zeroes every entry after reset.
module rmw_mem
    import rmw_mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 8,
    parameter  int OFFSET = 4,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic [1:0]        io_req_op,
    input  logic [ADDR_W-1:0] io_req_addr,
    input  logic [DATA_W-1:0] io_req_data,
    output logic              io_resp_valid,
    output logic [DATA_W-1:0] io_resp_data,
    output logic              io_busy
);

    // Handshake: a request transfers on any cycle where io_req_valid && io_req_ready;
    // the response follows exactly one cycle later and cannot be stalled.

    localparam logic [ADDR_W-1:0] COPY_OFF = ADDR_W'(OFFSET % DEPTH);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt;

    logic              accept;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] s1_old, s1_src;

    logic              s2_valid;
    op_t               s2_op;
    logic [ADDR_W-1:0] s2_addr;
    logic [DATA_W-1:0] s2_data, s2_old, s2_src, s2_new;
    logic              s2_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nx     = state;
        io_req_ready = 1'b0;
        io_busy      = 1'b1;
        unique case (state)
            ST_CLEAR: if (clr_cnt == LAST) state_nx = ST_RUN;
            ST_RUN: begin
                io_req_ready = 1'b1;
                io_busy      = 1'b0;
            end
            default: state_nx = ST_CLEAR;
        endcase
    end

    assign accept   = io_req_valid && io_req_ready;
    assign src_addr = io_req_addr + COPY_OFF;

    // A stage-2 write lands at the same edge stage 1 captures, so bypass the array.
    always_comb begin
        s1_old = mem[io_req_addr];
        s1_src = mem[src_addr];
        if (s2_valid && s2_we && (s2_addr == io_req_addr)) s1_old = s2_new;
        if (s2_valid && s2_we && (s2_addr == src_addr))    s1_src = s2_new;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_old   <= '0;
        end else begin
            s2_valid <= accept;
            if (accept) s2_old <= s1_old;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s2_op   <= op_t'(io_req_op);
            s2_addr <= io_req_addr;
            s2_data <= io_req_data;
            s2_src  <= s1_src;
        end
    end

    rmw_mem_alu #(.DATA_W(DATA_W)) u_alu (
        .op      (s2_op),
        .old_val (s2_old),
        .src_val (s2_src),
        .wr_data (s2_data),
        .new_val (s2_new),
        .we      (s2_we)
    );

    // Reset drops the in-flight op; the array itself is only initialised by the walk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR)       mem[clr_cnt] <= '0;
            else if (s2_valid && s2_we)  mem[s2_addr] <= s2_new;
        end
    end

    assign io_resp_valid = s2_valid;
    assign io_resp_data  = s2_old;

endmodule

// File: tb/tb_rmw_mem.sv
// Directed bench for rmw_mem: sequential memory model, per-cycle compare, literal pins.
module tb_rmw_mem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int OFFSET = 4;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset;
    logic              io_req_valid;
    logic              io_req_ready;
    logic [1:0]        io_req_op;
    logic [ADDR_W-1:0] io_req_addr;
    logic [DATA_W-1:0] io_req_data;
    logic              io_resp_valid;
    logic [DATA_W-1:0] io_resp_data;
    logic              io_busy;

    int checks = 0;
    int errors = 0;

    rmw_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OFFSET(OFFSET)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_req_valid  (io_req_valid),
        .io_req_ready  (io_req_ready),
        .io_req_op     (io_req_op),
        .io_req_addr   (io_req_addr),
        .io_req_data   (io_req_data),
        .io_resp_valid (io_resp_valid),
        .io_resp_data  (io_resp_data),
        .io_busy       (io_busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // Memory with strictly sequential op semantics; after reset every entry reads 0
    // and no request is taken until DEPTH cycles of clearing have elapsed.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_clear_left = 0;
    bit                m_init = 1'b0;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] lit_q [$];

    always @(posedge clk) begin
        if (reset) begin
            m_init       = 1'b1;
            m_clear_left = DEPTH;
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (m_clear_left > 0) begin
            m_clear_left = m_clear_left - 1;
        end else if (io_req_valid) begin
            logic [DATA_W-1:0] old_v;
            int                src;
            old_v = m_mem[io_req_addr];
            src   = (int'(io_req_addr) + OFFSET) % DEPTH;
            exp_q.push_back(old_v);
            case (io_req_op)
                2'd1: m_mem[io_req_addr] = old_v + 1;
                2'd2: m_mem[io_req_addr] = m_mem[src];
                2'd3: m_mem[io_req_addr] = io_req_data;
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (m_init) begin
            logic exp_rdy;
            logic exp_rv;
            exp_rdy = (m_clear_left == 0);
            exp_rv  = (exp_q.size() != 0);
            checks++;
            if (io_req_ready !== exp_rdy || io_busy !== !exp_rdy) begin
                errors++;
                $display("FAIL ready_busy t=%0t: ready=%b busy=%b, required ready=%b busy=%b",
                         $time, io_req_ready, io_busy, exp_rdy, !exp_rdy);
            end
            checks++;
            if (io_resp_valid !== exp_rv) begin
                errors++;
                $display("FAIL resp_valid t=%0t: got %b, required %b", $time, io_resp_valid, exp_rv);
            end
            if (exp_rv) begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                checks++;
                if (io_resp_data !== e) begin
                    errors++;
                    $display("FAIL resp_model t=%0t: got 0x%08h, required 0x%08h", $time, io_resp_data, e);
                end
                if (lit_q.size() != 0) begin
                    e = lit_q.pop_front();
                    checks++;
                    if (io_resp_data !== e) begin
                        errors++;
                        $display("FAIL resp_literal t=%0t: got 0x%08h, required 0x%08h",
                                 $time, io_resp_data, e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end at #1 after a rising edge.
    task automatic send(input logic [1:0] op, input int addr, input logic [DATA_W-1:0] data,
                        input logic [DATA_W-1:0] exp_lit);
        checks++;
        if (io_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: ready=%b, required 1 before op=%0d addr=%0d", io_req_ready, op, addr);
        end
        io_req_valid = 1'b1;
        io_req_op    = op;
        io_req_addr  = ADDR_W'(addr);
        io_req_data  = data;
        lit_q.push_back(exp_lit);
        @(posedge clk); #1;
        io_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (io_busy === 1'b1 && cnt < 50) begin
            cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (cnt != DEPTH) begin
            errors++;
            $display("FAIL %s: busy for %0d cycles, required %0d", name, cnt, DEPTH);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        io_req_valid = 1'b0;
        io_req_op    = 2'd0;
        io_req_addr  = '0;
        io_req_data  = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b0 || io_resp_data !== '0 || io_req_ready !== 1'b0 || io_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: rv=%b rd=0x%08h rdy=%b busy=%b, required 0 0 0 1",
                     io_resp_valid, io_resp_data, io_req_ready, io_busy);
        end
        count_busy("clear_len");

        for (int a = 0; a < DEPTH; a++) send(2'd0, a, '0, 32'h0);

        send(2'd1, 3, '0, 32'd0);
        send(2'd1, 3, '0, 32'd1);
        send(2'd1, 3, '0, 32'd2);
        send(2'd0, 3, '0, 32'd3);

        send(2'd3, 6, 32'h55, 32'h0);
        send(2'd2, 2, '0, 32'h0);
        send(2'd0, 2, '0, 32'h55);

        send(2'd3, 3, 32'hA, 32'd3);
        send(2'd2, 7, '0, 32'h0);
        send(2'd0, 7, '0, 32'hA);

        send(2'd3, 1, 32'hFFFF_FFFF, 32'h0);
        send(2'd1, 1, '0, 32'hFFFF_FFFF);
        send(2'd0, 1, '0, 32'h0);
        idle(2);

        send(2'd3, 5, 32'h9, 32'h0);
        reset        = 1'b1;
        io_req_valid = 1'b1;
        io_req_op    = 2'd0;
        io_req_addr  = 3'd5;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: resp_valid=%b, required 0", io_resp_valid);
        end
        count_busy("reclear_len");
        io_req_valid = 1'b0;
        send(2'd0, 5, '0, 32'h0);
        idle(3);

        checks++;
        if (exp_q.size() != 0 || lit_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d model / %0d literal responses outstanding, required 0",
                     exp_q.size(), lit_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rmw_mem.md
Name: rmw_mem

Overview:
- Parametrised read-modify-write register memory. Successor to the fixed 8x32 conditional-write memory.
- Adds four opcodes, a valid/ready request handshake, a response channel returning the pre-op value, and a 2-stage pipeline with hazard forwarding.
- Adds a post-reset clear sequence that zeroes every entry.
- Sits beside datapath counters/tables that need atomic increment, copy and write on small memories.

Parameters:
- DATA_W, 32, entry width in bits.
- DEPTH, 8, number of entries; power of two, >= 2.
- OFFSET, 4, source distance for COPY; taken modulo DEPTH.
- ADDR_W, log2(DEPTH), derived; not overridable.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- io_req_valid  in  1  request present.
- io_req_ready  out  1  block accepts a request this cycle.
- io_req_op  in  2  0 READ, 1 INC, 2 COPY, 3 WRITE.
- io_req_addr  in  ADDR_W  target entry.
- io_req_data  in  DATA_W  write data, used by WRITE only.
- io_resp_valid  out  1  response present; no back-pressure.
- io_resp_data  out  DATA_W  value of the target entry before the op.
- io_busy  out  1  clear sequence in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: io_req_ready=0, io_resp_valid=0, io_resp_data=0, io_busy=1. Pipeline valid bits are cleared.
- State machine: CLEAR -> RUN.
  - CLEAR: counter walks 0..DEPTH-1, writing 0 to one entry per cycle. io_req_ready=0, io_busy=1. Takes exactly DEPTH cycles, then moves to RUN.
  - RUN: io_req_ready=1, io_busy=0. Stays in RUN until reset.
- Acceptance: a request is accepted on a cycle where io_req_valid && io_req_ready. Throughput is one op per cycle.
- Pipeline:
  - Stage 1 (accept cycle N): register op, addr, data, the target-entry value, and the COPY source value mem[(addr+OFFSET) mod DEPTH].
  - Stage 2 (cycle N+1): io_resp_valid=1 and io_resp_data = pre-op target value. The new value is written at the N+1 clock edge.
- New value per op:
  - READ: no write.
  - INC: old+1, modulo 2^DATA_W.
  - COPY: source value.
  - WRITE: io_req_data.
- Forwarding:
  - If the stage-2 op writes address W and a stage-1 read (target or COPY source) hits W in the same cycle, stage 1 captures the stage-2 new value, not the array value.
  - Back-to-back ops therefore see strictly sequential semantics.
- Self-copy: COPY with OFFSET mod DEPTH == 0 copies an entry to itself; the value is unchanged.
- Address arithmetic: ADDR_W bits, wrap-around with no overflow flag.
- Requests while not ready: ignored; no response is produced.
- Reset mid-operation: the in-flight stage-2 op is dropped (no write, io_resp_valid=0 on the next cycle). The FSM re-enters CLEAR.
- The array itself has no reset; only the CLEAR walk initialises it.

Decomposition:
- Package rmw_mem_pkg:
  - op encodings OP_READ/OP_INC/OP_COPY/OP_WRITE;
  - FSM state encodings ST_CLEAR/ST_RUN;
  - clog2 function.
- One sub-module, rmw_mem_alu: combinational op x old x src x data -> new value plus a write-enable. Keeps opcode decode out of the pipeline and forwarding logic.

Test Plan:
- Reset for 1 cycle, then release:
  - io_busy=1 and io_req_ready=0 for exactly 8 cycles, then ready=1.
  - READ of every addr 0..7 -> io_resp_data=0, one cycle after each accept.
- Back-to-back INC on addr 3, three consecutive cycles -> resp 0,1,2; following READ addr 3 -> 3 (forwarding path).
- WRITE 0x55 to addr 6, next cycle COPY addr 2 (source 6) -> COPY resp 0; READ addr 2 -> 0x55.
- COPY wrap: WRITE 0xA to addr 3, then COPY addr 7 -> source (7+4) mod 8 = 3; READ addr 7 -> 0xA.
- INC overflow: WRITE 0xFFFFFFFF to addr 1, INC addr 1 -> resp 0xFFFFFFFF; READ addr 1 -> 0.
- Reset mid-op:
  - WRITE 0x9 to addr 5 accepted, reset asserted the next cycle -> io_resp_valid=0 and CLEAR re-runs for 8 cycles.
  - READ addr 5 -> 0.
  - io_req_valid held high during CLEAR produces no responses.
